// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects, load-use bubble FSM,
// single-entry MDU result scoreboard and a saturating stall counter.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             br_selE,
    input  logic             wb_selE,
    input  logic             wb_selM,
    input  logic             rd_wrenE,
    input  logic             rd_wrenM,
    input  logic             rd_wrenW,
    input  logic [AW-1:0]    rs1_addrD,
    input  logic [AW-1:0]    rs2_addrD,
    input  logic [AW-1:0]    rd_addrD,
    input  logic [AW-1:0]    rs1_addrE,
    input  logic [AW-1:0]    rs2_addrE,
    input  logic [AW-1:0]    rd_addrE,
    input  logic [AW-1:0]    rd_addrM,
    input  logic [AW-1:0]    rd_addrW,
    input  logic             rd_wrenD,
    input  logic             mdu_reqD,
    input  logic             mdu_startE,
    input  logic             mdu_done,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forward1sel,
    output logic [1:0]       forward2sel,
    output logic [1:0]       rs1d_sel,
    output logic [1:0]       rs2d_sel,
    output logic             mdu_pending,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [1:0]       LCNT_INIT = 2'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_lcnt, w_lcnt_nxt;
    logic             r_pend_v;
    logic [AW-1:0]    r_pend_rd;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lh, w_sh, w_raw, w_stall;

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] rs, input logic [AW-1:0] rdm,
                                         input logic wenm, input logic [AW-1:0] rdw,
                                         input logic wenw);
        if (rs == '0)                 return 2'b00;
        else if (wenm && rdm == rs)   return 2'b01;
        else if (wenw && rdw == rs)   return 2'b10;
        else                          return 2'b00;
    endfunction

    // Forwarding into D: a load still in M can only be taken after its data returns (11).
    function automatic logic [1:0] fwd_d(input logic [AW-1:0] rs, input logic [AW-1:0] rde,
                                         input logic wene, input logic [AW-1:0] rdm,
                                         input logic wenm, input logic wbm);
        if (rs == '0)                 return 2'b00;
        else if (wene && rde == rs)   return 2'b01;
        else if (wenm && rdm == rs)   return wbm ? 2'b11 : 2'b10;
        else                          return 2'b00;
    endfunction

    always_comb begin
        forward1sel = fwd_e(rs1_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
        forward2sel = fwd_e(rs2_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
        rs1d_sel    = fwd_d(rs1_addrD, rd_addrE, rd_wrenE, rd_addrM, rd_wrenM, wb_selM);
        rs2d_sel    = fwd_d(rs2_addrD, rd_addrE, rd_wrenE, rd_addrM, rd_wrenM, wb_selM);
    end

    assign w_lh  = wb_selE & rd_wrenE & (rd_addrE != '0) &
                   ((rs1_addrD == rd_addrE) | (rs2_addrD == rd_addrE));
    assign w_raw = (r_pend_rd != '0) & ((r_pend_rd == rs1_addrD) | (r_pend_rd == rs2_addrD));
    // A finishing MDU op is bypassed by the register file, so it no longer blocks D.
    assign w_sh  = r_pend_v & ~mdu_done &
                   (w_raw | (rd_wrenD & (rd_addrD == r_pend_rd)) | mdu_reqD);

    assign w_stall     = ((r_state == S_IDLE) & w_lh) | (r_state == S_WAIT) | w_sh;
    assign stallF      = w_stall & ~br_selE;
    assign stallD      = w_stall & ~br_selE;
    assign flushD      = br_selE;
    assign flushE      = br_selE | w_stall;
    assign mdu_pending = r_pend_v;
    assign stall_cnt   = r_stall_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        if (br_selE) begin
            w_state_nxt = S_IDLE;
            w_lcnt_nxt  = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_lh && LOAD_STALL > 1) begin
                    w_state_nxt = S_WAIT;
                    w_lcnt_nxt  = LCNT_INIT;
                end
                S_WAIT: if (r_lcnt == 2'd1) begin
                    w_state_nxt = S_IDLE;
                    w_lcnt_nxt  = 2'd0;
                end else begin
                    w_lcnt_nxt  = r_lcnt - 2'd1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_lcnt_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_lcnt      <= 2'd0;
            r_pend_v    <= 1'b0;
            r_pend_rd   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
            // A new launch overrides a same-cycle completion of the previous op.
            if (mdu_startE && rd_addrE != '0) begin
                r_pend_v  <= 1'b1;
                r_pend_rd <= rd_addrE;
            end else if (mdu_done) begin
                r_pend_v  <= 1'b0;
            end
            if (stallD && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: two hazard_scoreboard instances (LOAD_STALL=1/CNT_W=16 and LOAD_STALL=3/CNT_W=4)
// share one directed stimulus stream and are checked every cycle against a behavioural model.
module tb_hazard_scoreboard;
    localparam int AW = 5;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic br_selE, wb_selE, wb_selM, rd_wrenE, rd_wrenM, rd_wrenW;
    logic [AW-1:0] rs1_addrD, rs2_addrD, rd_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW;
    logic rd_wrenD, mdu_reqD, mdu_startE, mdu_done;

    typedef struct packed {
        logic       stallF, stallD, flushD, flushE;
        logic [1:0] f1, f2, d1, d2;
        logic       pend;
    } outs_t;

    outs_t a1, a3;
    logic [15:0] cnt_1;
    logic [3:0]  cnt_3;

    int npass = 0;
    int ntot  = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(.AW(AW), .LOAD_STALL(1), .CNT_W(16)) u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_selE(br_selE), .wb_selE(wb_selE), .wb_selM(wb_selM),
        .rd_wrenE(rd_wrenE), .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW),
        .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD), .rd_addrD(rd_addrD),
        .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rd_addrE(rd_addrE),
        .rd_addrM(rd_addrM), .rd_addrW(rd_addrW), .rd_wrenD(rd_wrenD), .mdu_reqD(mdu_reqD),
        .mdu_startE(mdu_startE), .mdu_done(mdu_done),
        .stallF(a1.stallF), .stallD(a1.stallD), .flushD(a1.flushD), .flushE(a1.flushE),
        .forward1sel(a1.f1), .forward2sel(a1.f2), .rs1d_sel(a1.d1), .rs2d_sel(a1.d2),
        .mdu_pending(a1.pend), .stall_cnt(cnt_1));

    hazard_scoreboard #(.AW(AW), .LOAD_STALL(3), .CNT_W(4)) u3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_selE(br_selE), .wb_selE(wb_selE), .wb_selM(wb_selM),
        .rd_wrenE(rd_wrenE), .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW),
        .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD), .rd_addrD(rd_addrD),
        .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rd_addrE(rd_addrE),
        .rd_addrM(rd_addrM), .rd_addrW(rd_addrW), .rd_wrenD(rd_wrenD), .mdu_reqD(mdu_reqD),
        .mdu_startE(mdu_startE), .mdu_done(mdu_done),
        .stallF(a3.stallF), .stallD(a3.stallD), .flushD(a3.flushD), .flushE(a3.flushE),
        .forward1sel(a3.f1), .forward2sel(a3.f2), .rs1d_sel(a3.d1), .rs2d_sel(a3.d2),
        .mdu_pending(a3.pend), .stall_cnt(cnt_3));

    // Model state per instance: remaining load bubbles, pending MDU dest, stall count.
    int m_left [2];
    bit m_pv   [2];
    int m_prd  [2];
    int m_cnt  [2];
    int ls_of  [2] = '{1, 3};
    int cmax   [2] = '{65535, 15};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    endtask

    function automatic bit load_hz();
        return wb_selE && rd_wrenE && rd_addrE != 0 &&
               (rs1_addrD == rd_addrE || rs2_addrD == rd_addrE);
    endfunction

    function automatic logic [1:0] sel_e(input int rs);
        if (rs == 0) return 0;
        if (rd_wrenM && rd_addrM == rs) return 1;
        if (rd_wrenW && rd_addrW == rs) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] sel_d(input int rs);
        if (rs == 0) return 0;
        if (rd_wrenE && rd_addrE == rs) return 1;
        if (rd_wrenM && rd_addrM == rs) return wb_selM ? 3 : 2;
        return 0;
    endfunction

    function automatic outs_t model(input int k);
        outs_t o;
        bit sh, st;
        sh = m_pv[k] && !mdu_done &&
             ((m_prd[k] != 0 && (m_prd[k] == rs1_addrD || m_prd[k] == rs2_addrD)) ||
              (rd_wrenD && rd_addrD == m_prd[k]) || mdu_reqD);
        st = (m_left[k] > 0) || load_hz() || sh;
        o.stallF = st && !br_selE;
        o.stallD = st && !br_selE;
        o.flushD = br_selE;
        o.flushE = br_selE || st;
        o.f1 = sel_e(rs1_addrE);
        o.f2 = sel_e(rs2_addrE);
        o.d1 = sel_d(rs1_addrD);
        o.d2 = sel_d(rs2_addrD);
        o.pend = m_pv[k];
        return o;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] = 0; m_pv[k] = 0; m_prd[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                outs_t o;
                o = model(k);
                if (o.stallD && m_cnt[k] < cmax[k]) m_cnt[k]++;
                if (br_selE)             m_left[k] = 0;
                else if (m_left[k] > 0)  m_left[k]--;
                else if (load_hz())      m_left[k] = ls_of[k] - 1;
                if (mdu_startE && rd_addrE != 0) begin
                    m_pv[k] = 1; m_prd[k] = rd_addrE;
                end else if (mdu_done) m_pv[k] = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        chk("u1_outs", 32'(a1), 32'(model(0)));
        chk("u3_outs", 32'(a3), 32'(model(1)));
        chk("u1_cnt", 32'(cnt_1), 32'(m_cnt[0]));
        chk("u3_cnt", 32'(cnt_3), 32'(m_cnt[1]));
    end

    task automatic clr();
        {br_selE, wb_selE, wb_selM, rd_wrenE, rd_wrenM, rd_wrenW} = '0;
        {rs1_addrD, rs2_addrD, rd_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW} = '0;
        {rd_wrenD, mdu_reqD, mdu_startE, mdu_done} = '0;
    endtask

    task automatic nxt();
        @(posedge clk_i); #1;
    endtask

    task automatic load_hazard();
        clr(); wb_selE = 1; rd_wrenE = 1; rd_addrE = 5; rs1_addrD = 5;
    endtask

    initial begin
        clr();
        rst_ni = 0;
        @(negedge clk_i);
        chk("rst_cnt3", 32'(cnt_3), 0);
        chk("rst_pend", 32'(a1.pend), 0);
        nxt(); rst_ni = 1;
        nxt();

        // Load-use bubble: 1 cycle on u1, 3 cycles on u3
        load_hazard();
        @(negedge clk_i);
        chk("ls1_stallF", 32'(a1.stallF), 1);
        chk("ls1_flushE", 32'(a1.flushE), 1);
        chk("ls1_d1", 32'(a1.d1), 1);
        nxt(); clr();
        @(negedge clk_i);
        chk("ls1_stall_c2", 32'(a1.stallD), 0);
        chk("ls1_cnt", 32'(cnt_1), 1);
        chk("ls3_stall_c2", 32'(a3.stallD), 1);
        nxt();
        @(negedge clk_i);
        chk("ls3_stall_c3", 32'(a3.stallD), 1);
        nxt();
        @(negedge clk_i);
        chk("ls3_stall_c4", 32'(a3.stallD), 0);
        chk("ls3_cnt", 32'(cnt_3), 3);
        nxt();

        // Branch on the second bubble cycle cancels the load stall
        load_hazard();
        nxt(); clr(); br_selE = 1;
        @(negedge clk_i);
        chk("br_stallD", 32'(a3.stallD), 0);
        chk("br_flushD", 32'(a3.flushD), 1);
        chk("br_flushE", 32'(a3.flushE), 1);
        nxt(); clr();
        @(negedge clk_i);
        chk("br_idle", 32'(a3.stallD), 0);
        chk("br_cnt3", 32'(cnt_3), 4);
        nxt();

        // MDU RAW on rs2 until completion
        mdu_startE = 1; rd_addrE = 7;
        nxt(); clr(); rs2_addrD = 7;
        @(negedge clk_i);
        chk("mdu_stall1", 32'(a3.stallD), 1);
        chk("mdu_pend1", 32'(a3.pend), 1);
        nxt();
        @(negedge clk_i);
        chk("mdu_stall2", 32'(a1.stallD), 1);
        nxt(); mdu_done = 1;
        @(negedge clk_i);
        chk("mdu_done_nostall", 32'(a3.stallD), 0);
        chk("mdu_done_pend", 32'(a3.pend), 1);
        nxt(); mdu_done = 0;
        @(negedge clk_i);
        chk("mdu_cleared", 32'(a3.pend), 0);
        chk("mdu_cnt3", 32'(cnt_3), 6);
        nxt(); clr();

        // rd=0 launch and forwarding priorities
        mdu_startE = 1; rd_addrE = 0;
        nxt(); clr();
        rs1_addrE = 3; rd_addrM = 3; rd_wrenM = 1; rd_addrW = 3; rd_wrenW = 1; rs2_addrE = 4;
        @(negedge clk_i);
        chk("x0_pend", 32'(a1.pend), 0);
        chk("fwd1_M", 32'(a1.f1), 1);
        chk("fwd2_none", 32'(a1.f2), 0);
        nxt(); rd_wrenM = 0;
        @(negedge clk_i);
        chk("fwd1_W", 32'(a3.f1), 2);
        nxt(); clr();
        rs1_addrD = 3; rs2_addrD = 3; rd_addrM = 3; rd_wrenM = 1; wb_selM = 1;
        @(negedge clk_i);
        chk("dsel_load", 32'(a1.d1), 3);
        nxt(); wb_selM = 0; rd_addrE = 3; rd_wrenE = 1; rs2_addrD = 0;
        @(negedge clk_i);
        chk("dsel_E", 32'(a1.d1), 1);
        chk("dsel_x0", 32'(a1.d2), 0);
        nxt(); clr();

        // WAW, structural, branch with pending op
        mdu_startE = 1; rd_addrE = 9;
        nxt(); clr(); rd_wrenD = 1; rd_addrD = 9;
        @(negedge clk_i);
        chk("waw_stall", 32'(a1.stallD), 1);
        nxt(); clr(); mdu_reqD = 1;
        @(negedge clk_i);
        chk("struct_stall", 32'(a3.stallD), 1);
        nxt(); br_selE = 1;
        @(negedge clk_i);
        chk("br_pend_stallD", 32'(a3.stallD), 0);
        nxt(); br_selE = 0;
        @(negedge clk_i);
        chk("br_keeps_pend", 32'(a3.pend), 1);

        // Saturation: hold the structural stall for 18 cycles
        for (int i = 0; i < 18; i++) nxt();
        @(negedge clk_i);
        chk("sat_cnt3", 32'(cnt_3), 15);
        nxt();
        rst_ni = 0;
        #1;
        chk("rst_mid_cnt", 32'(cnt_3), 0);
        chk("rst_mid_pend", 32'(a3.pend), 0);
        nxt(); clr(); rst_ni = 1;
        @(negedge clk_i);
        chk("post_rst_stall", 32'(a3.stallD), 0);
        nxt();
        @(negedge clk_i);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
